// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Scoreboard for registers with outstanding variable-latency writes
//   (multiply/divide results, memory loads). Each architectural register
//   has a down-counter that holds the number of non-frozen edges left until
//   its result is written back. Decode is stalled on RAW, WAW and write-back
//   port collisions. Each completed write-back is reported for one cycle.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   freeze       memory stall; holds every register in the block
//   flush        cancels this cycle's issue (stall is still computed)
//   issue_valid  Decode requests issue
//   issue_lat    result latency (0 = single-cycle, not tracked)
//   issue_dest   destination register
//   issue_rs     source register A
//   issue_rt     source register B
//   stall        combinational; Decode must hold
//   busy_rs      combinational; issue_rs has an outstanding write
//   busy_rt      combinational; issue_rt has an outstanding write
//   wb_valid     registered; a tracked result completed at the last edge
//   wb_reg       registered; register that completed
//   pending      registered; number of registers with a nonzero counter
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 8,
  localparam int CW     = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [CW-1:0]     issue_lat,
  input  logic [REG_AW-1:0] issue_dest,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0] issue_rt,
  output logic              stall,
  output logic              busy_rs,
  output logic              busy_rt,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_reg,
  output logic [REG_AW:0]   pending
);

  localparam int NREG = 1 << REG_AW;

  logic [CW-1:0]   cnt      [NREG];
  logic [CW-1:0]   cnt_next [NREG];
  logic [NREG-1:0] nz;
  logic [NREG-1:0] done;
  logic [NREG-1:0] hit;

  logic [CW-1:0]   lat_sat;
  logic [CW:0]     lat_plus1;
  logic            tracked;
  logic            waw;
  logic            wbc;
  logic            load;
  logic            done_any;
  logic [REG_AW-1:0] done_reg;
  logic [REG_AW:0]   pending_next;

  // Out-of-range latencies are clamped rather than rejected.
  assign lat_sat   = (issue_lat > CW'(MAX_LAT)) ? CW'(MAX_LAT) : issue_lat;
  assign lat_plus1 = {1'b0, lat_sat} + (CW + 1)'(1);
  assign tracked   = (lat_sat != '0) && (issue_dest != '0);

  // Per-register status bits. A counter equal to lat+1 would reach zero on
  // the same edge as the new result, so it is a write-back port collision.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    assign nz[gi]   = (cnt[gi] != '0);
    assign done[gi] = (gi != 0) && (cnt[gi] == CW'(1));
    assign hit[gi]  = ({1'b0, cnt[gi]} == lat_plus1);
  end

  assign busy_rs = (issue_rs != '0) && nz[issue_rs];
  assign busy_rt = (issue_rt != '0) && nz[issue_rt];
  assign waw     = tracked && nz[issue_dest];
  assign wbc     = tracked && (|hit);
  assign stall   = issue_valid && (busy_rs || busy_rt || waw || wbc);
  assign load    = issue_valid && !stall && !flush && !freeze && tracked;

  // Decrement everything, then let a new issue overwrite its destination.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_next[r] = cnt[r];
      if (!freeze && nz[r]) begin
        cnt_next[r] = cnt[r] - CW'(1);
      end
    end
    if (load) begin
      cnt_next[issue_dest] = lat_sat;
    end
    cnt_next[0] = '0;
  end

  // Lowest completing register wins if more than one ever completes.
  always_comb begin
    done_any = |done;
    done_reg = '0;
    for (int r = NREG - 1; r >= 1; r--) begin
      if (done[r]) begin
        done_reg = REG_AW'(r);
      end
    end
  end

  always_comb begin
    pending_next = '0;
    for (int r = 1; r < NREG; r++) begin
      if (cnt_next[r] != '0) begin
        pending_next = pending_next + (REG_AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      wb_valid <= 1'b0;
      wb_reg   <= '0;
      pending  <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_next[r];
      end
      if (!freeze) begin
        wb_valid <= done_any;
        if (done_any) begin
          wb_reg <= done_reg;
        end
        pending <= pending_next;
      end
    end
  end

endmodule
